// File: rtl/synthesizer_soc_hex_scan_driver.sv
// synthesizer_soc_hex_scan_driver
// Four-digit multiplexed seven-segment driver fed by the hex-digits PIO.
// The displayed value is snapshotted once per frame so CPU writes never tear.
// Each digit slot starts with GUARD_CYCLES of dark segments (anti-ghosting).
// Optional feature macro: HEX_SCAN_LZB_EN (leading-zero blanking of digits 3..1).
module synthesizer_soc_hex_scan_driver #(
  parameter int DIGIT_PERIOD = 12500,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] hex_value,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic [3:0]  digit_sel_n,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;
  logic          tick_q, tick_d;
  logic          slot_end;
  logic          past_guard;
  logic          blank;
  logic [3:0]    nib;

  // Active-low segment pattern for one hex nibble (a..g on bits 0..6).
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt_q == CW'(DIGIT_PERIOD - 1));
  assign nib      = snap_q[{idx_q, 2'b00} +: 4];

  // A zero guard means segments are lit from the first cycle of a slot.
  generate
    if (GUARD_CYCLES == 0) begin : g_noguard
      assign past_guard = 1'b1;
    end else begin : g_guard
      assign past_guard = (cnt_q >= CW'(GUARD_CYCLES));
    end
  endgenerate

`ifdef HEX_SCAN_LZB_EN
  // Digit k (k>0) is dark when it and every more-significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (snap_q[15:12] == 4'h0);
      2'd2:    blank = (snap_q[15:8]  == 8'h0);
      2'd1:    blank = (snap_q[15:4]  == 12'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Scan counters, frame snapshot and registered outputs (next-state logic).
  always_comb begin
    cnt_d  = '0;
    idx_d  = '0;
    snap_d = snap_q;
    tick_d = 1'b0;
    sel_d  = 4'hF;
    seg_d  = 7'h7F;
    if (!enable) begin
      // Track the PIO while dark so re-enable shows the current value.
      snap_d = hex_value;
    end else begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
      idx_d = slot_end ? idx_q + 2'd1 : idx_q;
      if (slot_end && idx_q == 2'd3) begin
        snap_d = hex_value;
        tick_d = 1'b1;
      end
      sel_d = ~(4'b0001 << idx_q);
      if (past_guard && !blank) seg_d = decode(nib);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      tick_q <= 1'b0;
      sel_q  <= 4'hF;
      seg_q  <= 7'h7F;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  assign seg_n       = seg_q;
  assign digit_sel_n = sel_q;
  assign frame_tick  = tick_q;

endmodule
